// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: issues one req/ack access per load/store,
// stalls the whole pipeline while it is outstanding, and flags memory timeouts.
module mem_access_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [63:0]      addr_in,
  input  logic [63:0]      wdata_in,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [63:0]      dmem_addr,
  output logic [63:0]      dmem_wdata,
  input  logic             dmem_ack,
  input  logic [63:0]      dmem_rdata,
  output logic [63:0]      load_data,
  output logic             stall,
  output logic             error,
  output logic [CNT_W-1:0] stall_count,
  output logic [1:0]       state_dbg
);

  // Handshake: dmem_req rises with address/data/we latched and holds them
  // stable until the memory returns a one-cycle dmem_ack (with dmem_rdata for
  // reads) or the timeout abandons the access; each request is acked at most once.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_next;
  logic        access;
  logic        stall_raw;
  logic        timeout_hit;
  logic [15:0] tmo_cnt;

  assign access      = mem_read | mem_write;
  assign timeout_hit = (tmo_cnt == TMO_LAST);
  // Held low during reset even if EX/MEM still presents an access.
  assign stall       = stall_raw & ~reset;
  assign state_dbg   = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    stall_raw  = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          stall_raw  = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        stall_raw = 1'b1;
        if (dmem_ack || timeout_hit) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      load_data  <= '0;
      error      <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            dmem_addr  <= addr_in;
            dmem_wdata <= wdata_in;
            dmem_we    <= mem_write;
            dmem_req   <= 1'b1;
            tmo_cnt    <= '0;
          end
        end
        BUSY: begin
          // Ack takes priority over a coinciding timeout.
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (!dmem_we) load_data <= dmem_rdata;
          end else if (timeout_hit) begin
            dmem_req  <= 1'b0;
            error     <= 1'b1;
            load_data <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            stall_count <= '0;
    else if (stall && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a driver issues directed accesses, a
// memory responder acks after a set latency, and a monitor checks each completion.
module tb_mem_access_ctrl;

  localparam int EW = 210;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic        clk;
  logic        reset;
  logic        mem_read, mem_write;
  logic [63:0] addr_in, wdata_in;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;
  logic [63:0] load_data;
  logic        stall, error;
  logic [31:0] stall_count;
  logic [1:0]  state_dbg;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  int          ack_lat   = 0;
  logic [63:0] rdata_val = '0;
  int          req_total = 0;

  mem_access_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write),
    .addr_in(addr_in), .wdata_in(wdata_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .load_data(load_data), .stall(stall), .error(error),
    .stall_count(stall_count), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  initial begin
    int busy_cnt;
    busy_cnt   = 0;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (dmem_req && !reset) begin
        busy_cnt++;
        if (ack_lat != 0 && busy_cnt == ack_lat) begin
          dmem_ack   = 1'b1;
          dmem_rdata = rdata_val;
        end else begin
          dmem_ack = 1'b0;
        end
      end else begin
        busy_cnt = 0;
        dmem_ack = 1'b0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic        cap_we, req_prev;
    logic [63:0] cap_addr, cap_wdata;
    int          req_cyc, stall_cyc;
    logic [EW-1:0] e;
    cap_we = 0; cap_addr = 0; cap_wdata = 0; req_prev = 0;
    req_cyc = 0; stall_cyc = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        req_cyc = 0; stall_cyc = 0; req_prev = 0;
      end else begin
        if (dmem_req) begin
          cap_we    = dmem_we;
          cap_addr  = dmem_addr;
          cap_wdata = dmem_wdata;
          req_cyc++;
          if (!req_prev) req_total++;
        end
        req_prev = dmem_req;
        if (stall) stall_cyc++;
        if (state_dbg == ST_DONE) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 64'(exp_q.size()), 64'd1);
          end else begin
            e = exp_q.pop_front();
            check("dmem_we",    64'(cap_we),    64'(e[209]));
            check("dmem_addr",  cap_addr,       e[208:145]);
            check("dmem_wdata", cap_wdata,      e[144:81]);
            check("load_data",  load_data,      e[80:17]);
            check("error",      64'(error),     64'(e[16]));
            check("req_cycles", 64'(req_cyc),   64'(e[15:8]));
            check("stall_cycles", 64'(stall_cyc), 64'(e[7:0]));
            check("stall_in_done", 64'(stall),  64'd0);
          end
          req_cyc = 0; stall_cyc = 0;
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 inside the DONE cycle.
  task automatic do_access(input logic rd, input logic wr,
                           input logic [63:0] addr, input logic [63:0] wdata,
                           input int lat, input logic [63:0] rdata,
                           input logic [63:0] exp_load, input logic exp_err,
                           input int exp_req, input int exp_stall);
    logic done;
    exp_q.push_back({wr, addr, wdata, exp_load, exp_err, 8'(exp_req), 8'(exp_stall)});
    ack_lat   = lat;
    rdata_val = rdata;
    mem_read  = rd;
    mem_write = wr;
    addr_in   = addr;
    wdata_in  = wdata;
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(posedge clk);
      #1;
      if (state_dbg == ST_DONE) done = 1'b1;
    end
    check("access_done", 64'(done), 64'd1);
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int req_before;
    reset = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
    addr_in = '0; wdata_in = '0;
    #12;
    check("rst_dmem_req",    64'(dmem_req),   64'd0);
    check("rst_dmem_we",     64'(dmem_we),    64'd0);
    check("rst_stall",       64'(stall),      64'd0);
    check("rst_error",       64'(error),      64'd0);
    check("rst_load_data",   load_data,       64'd0);
    check("rst_stall_count", 64'(stall_count), 64'd0);
    check("rst_state",       64'(state_dbg),  64'(ST_IDLE));
    mem_read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    idle_cycles(2);
    check("idle_stall", 64'(stall), 64'd0);

    // Load acked on 3rd BUSY cycle.
    do_access(1, 0, 64'h100, 64'h0, 3, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 0, 3, 4);
    check("stall_count_load", 64'(stall_count), 64'd4);
    idle_cycles(2);

    // Store, immediate ack; load_data must not pick up rdata.
    do_access(0, 1, 64'h08, 64'h55, 1, 64'h1234, 64'hDEAD_BEEF, 0, 1, 2);
    idle_cycles(1);

    // Read and write both set: treated as a write.
    do_access(1, 1, 64'h20, 64'h77, 2, 64'h9999, 64'hDEAD_BEEF, 0, 2, 3);
    idle_cycles(1);

    // Timeout (TIMEOUT=4): no ack.
    do_access(1, 0, 64'h40, 64'h0, 0, 64'h0, 64'h0, 1, 4, 5);
    idle_cycles(1);
    check("timeout_state_idle", 64'(state_dbg), 64'(ST_IDLE));

    // Following load completes; error stays sticky.
    do_access(1, 0, 64'h48, 64'h0, 2, 64'hCAFE, 64'hCAFE, 1, 2, 3);
    idle_cycles(1);

    // Back-to-back loads, next instruction presented during DONE.
    req_before = req_total;
    do_access(1, 0, 64'h200, 64'h0, 1, 64'h1111, 64'h1111, 1, 1, 2);
    do_access(1, 0, 64'h208, 64'h0, 1, 64'h2222, 64'h2222, 1, 1, 2);
    idle_cycles(3);
    check("b2b_requests", 64'(req_total - req_before), 64'd2);
    check("stall_count_total", 64'(stall_count), 64'd21);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of BUSY.
    ack_lat = 0; mem_read = 1'b1; addr_in = 64'h300;
    idle_cycles(2);
    check("pre_rst_busy", 64'(state_dbg), 64'(ST_BUSY));
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    check("midrst_dmem_req", 64'(dmem_req),  64'd0);
    check("midrst_stall",    64'(stall),     64'd0);
    check("midrst_state",    64'(state_dbg), 64'(ST_IDLE));
    mem_read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    idle_cycles(1);
    check("post_rst_state",       64'(state_dbg),   64'(ST_IDLE));
    check("post_rst_stall_count", 64'(stall_count), 64'd0);
    check("post_rst_error",       64'(error),       64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequences data-memory accesses for the MEM stage against a variable-latency memory with a req/ack handshake. It sits between the EX/MEM pipeline register outputs and the data memory. While an access is outstanding it raises a pipeline-wide stall, holding the write enables of IF/ID, ID/EX, EX/MEM and MEM/WB low. It returns load data to the MEM/WB path and flags memory timeouts.

Parameters:
TIMEOUT, 64, BUSY cycles without ack before the access is abandoned; legal range 2..65535.
CNT_W, 32, width of the stall-cycle performance counter.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
mem_read  input  1  EX/MEM stage holds a load (LDUR)
mem_write  input  1  EX/MEM stage holds a store (STUR)
addr_in  input  64  ALU_Result from EX/MEM (effective address)
wdata_in  input  64  WriteData from EX/MEM
dmem_req  output  1  request to data memory
dmem_we  output  1  1 = write, 0 = read; valid while dmem_req=1
dmem_addr  output  64  latched address
dmem_wdata  output  64  latched store data
dmem_ack  input  1  memory completion, one-cycle pulse
dmem_rdata  input  64  read data, valid with dmem_ack
load_data  output  64  registered load result to MEM/WB
stall  output  1  hold all pipeline registers (write=0)
error  output  1  sticky timeout flag
stall_count  output  CNT_W  saturating count of cycles with stall=1

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values: FSM=IDLE; dmem_req, dmem_we, error = 0; dmem_addr, dmem_wdata, load_data, stall_count = 0; timeout counter = 0. stall is combinational from state and reads 0 while reset is asserted.
- Access = mem_read | mem_write. If both are set, the access is a write: dmem_we=1 and load_data is unchanged.
- States: IDLE, BUSY, DONE.
- IDLE: if access=1, stall=1 in the same cycle (combinational). At the clock edge, latch addr_in, wdata_in and we=mem_write into the dmem_* registers, set dmem_req=1, clear the timeout counter, and go to BUSY. If access=0, stall=0 and the FSM stays in IDLE.
- BUSY: stall=1. dmem_req, dmem_we, dmem_addr and dmem_wdata are held stable.
  - On dmem_ack=1: dmem_req is cleared at the edge. For a read, load_data<=dmem_rdata. Go to DONE. An ack in the first BUSY cycle is legal, giving a minimum access of 2 stalled cycles.
  - Otherwise the counter increments. When counter==TIMEOUT-1 and ack=0: set error=1, load_data<=0, drop dmem_req, go to DONE.
  - If ack and timeout coincide, ack wins and error is not set.
- DONE: stall=0 for exactly one cycle, so the pipeline advances and the instruction leaves EX/MEM. Go to IDLE unconditionally. Inputs are ignored in DONE, so the same instruction is never served twice.
- dmem_ack outside BUSY is ignored.
- load_data holds its value until the next completed read or a timeout.
- error clears only on reset.
- stall_count increments on every cycle with stall=1 and saturates at all-ones.
- Reset mid-access (in BUSY): dmem_req drops immediately (asynchronously) and the FSM returns to IDLE. The memory must tolerate an abandoned request.
- Throughput: back-to-back accesses cost (latency+1) stalled cycles each, plus one DONE cycle between them.

Test Plan:
- Load, ack on the 3rd BUSY cycle: mem_read=1, addr_in=0x100, dmem_rdata=0xDEAD_BEEF with ack → dmem_req high 3 cycles with addr 0x100 and we=0; stall high 4 cycles (IDLE detect + 3 BUSY); load_data=0xDEAD_BEEF in DONE; stall=0 for one cycle; stall_count=4.
- Store with immediate ack: mem_write=1, addr_in=0x08, wdata_in=0x55 → dmem_we=1, dmem_wdata=0x55 for 1 cycle; stall high 2 cycles; load_data unchanged.
- Read and write both set: addr_in=0x20 → dmem_we=1, load_data untouched.
- Timeout: TIMEOUT=4, no ack → error=1 after the 4th BUSY cycle, load_data=0, FSM passes through DONE to IDLE. A following load acked normally completes with error still 1.
- Back-to-back loads (EX/MEM updated during DONE), each acked in its first BUSY cycle → exactly 2 requests, one per address. The sequence for each is stall 1,1 then 0 in DONE; no duplicate request.
- Reset asserted mid-BUSY: dmem_req and stall fall immediately without waiting for a clock edge; after release the FSM is in IDLE and stall_count=0.
